// File: rtl/vga_clkgen_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the VGA pixel clock DCM_CLKGEN programming sequencer.
package vga_clkgen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_D,
    ST_GAP1,
    ST_LOAD_M,
    ST_GAP2,
    ST_GO,
    ST_WAIT_DONE,
    ST_WAIT_LOCK
  } state_t;

  // Two-bit command codes occupy the first two bits shifted out of each load word.
  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_LOAD_M = 2'b11;

  localparam int WORD_BITS = 10;
  localparam int GAP_TICKS = 2;

endpackage

// File: rtl/vga_clkgen_sync2.sv
`timescale 1ns/1ps
// clkgen_sync2: two-flop synchronizer for DCM status inputs arriving asynchronously to sys_clk.
module clkgen_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/vga_clkgen_ctl.sv
`timescale 1ns/1ps
// vga_clkgen_ctl: reprograms the VGA pixel clock DCM_CLKGEN at run time.
// Shifts LoadD, LoadM and GO over PROGCLK/PROGDATA/PROGEN, then waits for PROGDONE and LOCKED.
module vga_clkgen_ctl
  import vga_clkgen_pkg::*;
#(
  parameter int PROG_HALF = 2,
  parameter int TIMEOUT   = 65536
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_m,
  input  logic [7:0] req_d,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       vga_progclk,
  output logic       vga_progdata,
  output logic       vga_progen,
  input  logic       vga_progdone,
  input  logic       vga_locked,
  output logic       locked
);

  localparam int DIV_W = (PROG_HALF > 1) ? $clog2(PROG_HALF) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_cnt;
  logic                 progclk_q, div_wrap, fall_tick;
  logic [3:0]           tick_cnt;
  logic [TO_W-1:0]      wait_cnt;
  logic                 wait_expired;
  logic [7:0]           m_q, d_q;
  logic [WORD_BITS-1:0] word_d, word_m;
  logic                 progdone_s, locked_s, low_seen_q;
  logic                 hs, hs_legal, done_ok;
  logic                 ready_q, busy_q, done_q, error_q, progen_q, progdata_q;
  logic                 ready_d, busy_d, done_d, error_d, progen_d, progdata_d;

  clkgen_sync2 u_sync_progdone (.clk(sys_clk), .rst_n(sys_rst_n), .d(vga_progdone), .q(progdone_s));
  clkgen_sync2 u_sync_locked   (.clk(sys_clk), .rst_n(sys_rst_n), .d(vga_locked),   .q(locked_s));

  assign hs           = req_valid & ready_q;
  assign hs_legal     = hs & (req_m != 8'd0);
  assign div_wrap     = (div_cnt == DIV_W'(PROG_HALF - 1));
  // Commands change as PROGCLK falls so the DCM samples them mid-period on its rising edge.
  assign fall_tick    = div_wrap & progclk_q;
  assign wait_expired = (wait_cnt == TO_W'(TIMEOUT - 1));
  // PROGDONE must be seen low during this command before its high counts as completion.
  assign done_ok      = low_seen_q & progdone_s;
  assign word_d       = {d_q, CMD_LOAD_D};
  assign word_m       = {m_q, CMD_LOAD_M};

  // Free-running PROGCLK divider, independent of the sequencer state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt   <= '0;
      progclk_q <= 1'b0;
    end else if (div_wrap) begin
      div_cnt   <= '0;
      progclk_q <= ~progclk_q;
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
    end
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state: shift and gap phases advance on fall ticks, wait phases on status or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (hs_legal) state_d = ST_LOAD_D;
      ST_LOAD_D:    if (fall_tick && tick_cnt == 4'(WORD_BITS - 1)) state_d = ST_GAP1;
      ST_GAP1:      if (fall_tick && tick_cnt == 4'(GAP_TICKS - 1)) state_d = ST_LOAD_M;
      ST_LOAD_M:    if (fall_tick && tick_cnt == 4'(WORD_BITS - 1)) state_d = ST_GAP2;
      ST_GAP2:      if (fall_tick && tick_cnt == 4'(GAP_TICKS - 1)) state_d = ST_GO;
      ST_GO:        if (fall_tick) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (done_ok) state_d = ST_WAIT_LOCK;
                    else if (wait_expired) state_d = ST_IDLE;
      ST_WAIT_LOCK: if (locked_s || wait_expired) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered handshake, status and PROG pins.
  always_comb begin
    ready_d    = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = 1'b0;
    error_d    = 1'b0;
    progen_d   = progen_q;
    progdata_d = progdata_q;
    if (fall_tick) begin
      case (state_q)
        ST_LOAD_D: begin progen_d = 1'b1; progdata_d = word_d[tick_cnt]; end
        ST_LOAD_M: begin progen_d = 1'b1; progdata_d = word_m[tick_cnt]; end
        ST_GO:     begin progen_d = 1'b1; progdata_d = 1'b0; end
        default:   begin progen_d = 1'b0; progdata_d = 1'b0; end
      endcase
    end
    case (state_q)
      ST_IDLE: if (hs && !hs_legal) error_d = 1'b1;
      ST_WAIT_DONE: if (!done_ok && wait_expired) begin
        error_d    = 1'b1;
        progen_d   = 1'b0;
        progdata_d = 1'b0;
      end
      ST_WAIT_LOCK: if (locked_s) begin
        done_d = 1'b1;
      end else if (wait_expired) begin
        error_d    = 1'b1;
        progen_d   = 1'b0;
        progdata_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Registered outputs, all cleared by reset so a mid-shift reset abandons the command.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      progen_q   <= 1'b0;
      progdata_q <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      progen_q   <= progen_d;
      progdata_q <= progdata_d;
    end
  end

  // Bit/gap counter restarts on every state change; wait counter reloads on entry to a wait state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      if (state_d != state_q) tick_cnt <= '0;
      else if (fall_tick)     tick_cnt <= tick_cnt + 4'd1;
      if (state_d != state_q) wait_cnt <= '0;
      else if (state_q == ST_WAIT_DONE || state_q == ST_WAIT_LOCK)
        wait_cnt <= wait_cnt + TO_W'(1);
    end
  end

  // Tracks a low PROGDONE anywhere since the command started.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)              low_seen_q <= 1'b0;
    else if (state_q == ST_IDLE) low_seen_q <= 1'b0;
    else if (!progdone_s)        low_seen_q <= 1'b1;
  end

  // Requested multiply/divide pair, captured on an accepted legal request.
  always_ff @(posedge sys_clk) begin
    if (hs_legal) begin
      m_q <= req_m;
      d_q <= req_d;
    end
  end

  assign req_ready    = ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign vga_progclk  = progclk_q;
  assign vga_progdata = progdata_q;
  assign vga_progen   = progen_q;
  assign locked       = locked_s;

endmodule

// File: tb/tb_vga_clkgen_ctl.sv
`timescale 1ns/1ps
// Self-checking bench for vga_clkgen_ctl with a behavioural DCM_CLKGEN programming-port model.
module tb_vga_clkgen_ctl;

  localparam int PROG_HALF = 2;
  localparam int TIMEOUT   = 100;

  logic       sys_clk, sys_rst_n;
  logic       req_valid, req_ready;
  logic [7:0] req_m, req_d;
  logic       busy, done, error;
  logic       vga_progclk, vga_progdata, vga_progen;
  logic       vga_progdone, vga_locked, locked;

  vga_clkgen_ctl #(.PROG_HALF(PROG_HALF), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_m(req_m), .req_d(req_d),
    .busy(busy), .done(done), .error(error),
    .vga_progclk(vga_progclk), .vga_progdata(vga_progdata), .vga_progen(vga_progen),
    .vga_progdone(vga_progdone), .vga_locked(vga_locked), .locked(locked)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Expected PROG pin values per fall tick: {is_go, progen, progdata}.
  logic [2:0] exp_q[$];
  // Expected outcomes: 1 = done, 2 = illegal-request error, 3 = timeout error.
  int res_q[$];

  bit   active = 0;
  bit   in_rst = 0;
  logic prev_clk = 0, prev_en = 0, prev_data = 0;
  int   go_cyc = 0, last_hs_edge = 0, last_res_cyc = 0, ready_cyc = 0;
  int   dcm_mode = 0;  // 0 normal, 1 progdone never rises, 2 progdone stuck high
  logic dcm_prev_en = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp_v, cyc);
    end
  endtask

  initial sys_clk = 0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // DCM model: a load command starts with data=1, GO starts with data=0.
  initial begin
    vga_progdone = 1'b0;
    vga_locked   = 1'b0;
    forever begin
      @(posedge vga_progclk);
      #1;
      if (vga_progen && !dcm_prev_en) begin
        if (vga_progdata) begin
          vga_progdone = (dcm_mode == 2);
          vga_locked   = 1'b0;
        end else if (dcm_mode == 0) begin
          repeat (5) @(posedge sys_clk);
          #1 vga_progdone = 1'b1;
          repeat (8) @(posedge sys_clk);
          #1 vga_locked = 1'b1;
        end
      end
      dcm_prev_en = vga_progen;
    end
  end

  // Monitor: pops PROG bit expectations on fall ticks and outcome expectations on done/error.
  always @(negedge sys_clk) begin
    logic fall;
    logic [2:0] e;
    int k;
    fall = prev_clk && !vga_progclk;
    if (!in_rst) begin
      if (!fall) begin
        chk("off_tick_change", 32'({vga_progen, vga_progdata}), 32'({prev_en, prev_data}));
      end else begin
        if (!active && exp_q.size() > 0 && vga_progen) begin
          active = 1;
          chk("first_bit_lat", 32'((cyc - last_hs_edge) >= 1 && (cyc - last_hs_edge) <= 2 * PROG_HALF), 1);
        end
        if (active) begin
          e = exp_q.pop_front();
          chk("prog_bits", 32'({vga_progen, vga_progdata}), 32'(e[1:0]));
          if (e[2]) go_cyc = cyc;
          if (exp_q.size() == 0) active = 0;
        end else begin
          chk("idle_progen", 32'(vga_progen), 0);
        end
      end
      if (done || error) begin
        chk("done_err_excl", 32'(done & error), 0);
        chk("busy_at_result", 32'(busy), 0);
        last_res_cyc = cyc;
        if (res_q.size() == 0) begin
          chk("unexpected_result", 32'({done, error}), 0);
        end else begin
          k = res_q.pop_front();
          case (k)
            1: begin
              chk("done_kind", 32'({done, error}), 2);
              chk("locked_at_done", 32'(locked), 1);
            end
            2: begin
              chk("illegal_kind", 32'({done, error}), 1);
              chk("illegal_lat", cyc, last_hs_edge);
            end
            default: begin
              chk("timeout_kind", 32'({done, error}), 1);
              chk("timeout_lat", cyc - go_cyc, TIMEOUT);
              chk("progen_at_err", 32'(vga_progen), 0);
            end
          endcase
        end
      end
    end
    prev_clk  = vga_progclk;
    prev_en   = vga_progen;
    prev_data = vga_progdata;
  end

  task automatic push_seq(input logic [7:0] m, input logic [7:0] d);
    logic [9:0] wd, wm;
    wd = {d, 2'b01};
    wm = {m, 2'b11};
    for (int i = 0; i < 10; i++) exp_q.push_back({2'b01, wd[i]});
    for (int i = 0; i < 2; i++)  exp_q.push_back(3'b000);
    for (int i = 0; i < 10; i++) exp_q.push_back({2'b01, wm[i]});
    for (int i = 0; i < 2; i++)  exp_q.push_back(3'b000);
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b000);
  endtask

  task automatic send(input logic [7:0] m, input logic [7:0] d, input int kind, input bit hold);
    int n;
    @(negedge sys_clk);
    req_m = m;
    req_d = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("hs_wait", 32'(n < 3000), 1);
    ready_cyc    = cyc;
    last_hs_edge = cyc + 1;
    if (kind != 2) push_seq(m, d);
    res_q.push_back(kind);
    @(negedge sys_clk);
    if (!hold) req_valid = 1'b0;
    chk("busy_after_hs", 32'(busy), 32'(kind != 2));
    chk("ready_after_hs", 32'(req_ready), 32'(kind == 2));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((res_q.size() != 0 || exp_q.size() != 0) && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("drain", res_q.size() + exp_q.size(), 0);
    res_q.delete();
    exp_q.delete();
    active = 0;
    repeat (6) @(negedge sys_clk);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    req_valid = 1'b0;
    req_m = 8'd0;
    req_d = 8'd0;
    in_rst = 1;

    // Reset values.
    repeat (3) @(negedge sys_clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done_error", 32'({done, error}), 0);
    chk("rst_prog_pins", 32'({vga_progclk, vga_progdata, vga_progen}), 0);
    chk("rst_locked", 32'(locked), 0);
    sys_rst_n = 1'b1;
    #1 chk("ready_before_edge", 32'(req_ready), 0);
    @(negedge sys_clk);
    in_rst = 0;
    chk("ready_after_release", 32'(req_ready), 1);
    repeat (4) @(negedge sys_clk);

    // Basic programming sequence completed by the DCM model.
    dcm_mode = 0;
    send(8'd1, 8'd3, 1, 0);
    drain();

    // Illegal multiplier.
    send(8'd0, 8'h10, 2, 0);
    drain();

    // Request held through an active sequence: exactly two transfers, second after done.
    send(8'h20, 8'h05, 1, 1);
    send(8'h20, 8'h05, 1, 0);
    chk("hold_accept_after_done", ready_cyc, last_res_cyc);
    drain();

    // PROGDONE stuck high: no low seen, so the wait times out.
    dcm_mode = 2;
    send(8'h7A, 8'hC3, 3, 0);
    drain();

    // PROGDONE never rises.
    dcm_mode = 1;
    send(8'h11, 8'h22, 3, 0);
    drain();

    // Asynchronous reset in the middle of LOAD_M, then a full clean sequence.
    dcm_mode = 0;
    send(8'h05, 8'h07, 1, 0);
    begin
      int n;
      n = 0;
      while (exp_q.size() > 9 && n < 2000) begin
        @(negedge sys_clk);
        n++;
      end
      chk("reach_load_m", 32'(n < 2000), 1);
    end
    @(posedge sys_clk);
    #1;
    in_rst = 1;
    sys_rst_n = 1'b0;
    exp_q.delete();
    res_q.delete();
    active = 0;
    #1;
    chk("mid_rst_outs",
        32'({req_ready, busy, done, error, vga_progclk, vga_progdata, vga_progen, locked}), 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("ready_after_mid_rst", 32'(req_ready), 1);
    in_rst = 0;
    repeat (4) @(negedge sys_clk);
    send(8'hFF, 8'h00, 1, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
